perf_event_reporter: RTL and testbench

Parametrised successor of the single-purpose miss counter feeding the FIFO/UART path in the FPGA top. It counts NUM_CH independent event strobes (cache reads, misses, writes, etc.) over a programmable window. At each window end, or on request, it snapshots all counts and streams them as a framed, checksummed byte packet over a valid/ready byte interface. That interface drives the byte FIFO in front of the UART transmitter directly.

---
 rtl/perf_rpt_pkg.sv | 23 ++
 rtl/perf_ch_counter.sv | 39 +++
 rtl/perf_event_reporter.sv | 138 +++++++++++++
 tb/tb_perf_event_reporter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/perf_rpt_pkg.sv
// Shared types and helpers for the performance event reporter.
package perf_rpt_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} rpt_state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bytes_per_ch(input int unsigned cnt_w);
    return cnt_w / BYTE_W;
  endfunction

  // Sync + seq + payload + checksum
  function automatic int unsigned frame_len(input int unsigned num_ch, input int unsigned cnt_w);
    return 3 + num_ch * bytes_per_ch(cnt_w);
  endfunction

  function automatic bit params_ok(input int unsigned num_ch, input int unsigned cnt_w,
                                   input int unsigned period);
    return (cnt_w % BYTE_W == 0) && (cnt_w >= 8) && (cnt_w <= 64) &&
           (period >= 2) && (num_ch >= 1) && (num_ch <= 32);
  endfunction

endpackage

// File: rtl/perf_ch_counter.sv
// One event channel: live counter plus shadow captured (and live cleared) on snapshot.
module perf_ch_counter
  import perf_rpt_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             event_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] shadow_o
);

  logic [CNT_W-1:0] live_q, live_d, shadow_q, sum_c;
  logic             inc_c;

  // The snapshot captures the sum so the trigger-cycle event is not lost
  always_comb begin
    inc_c = en_i & event_i;
    sum_c = live_q + CNT_W'(inc_c);
    if (SATURATE && inc_c && (live_q == '1)) sum_c = live_q;
    live_d = snap_i ? '0 : sum_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q   <= '0;
      shadow_q <= '0;
    end else begin
      live_q <= live_d;
      if (snap_i) shadow_q <= sum_c;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/perf_event_reporter.sv
// Counts NUM_CH event strobes per window and streams framed, checksummed snapshots
// over a valid/ready byte interface.
module perf_event_reporter
  import perf_rpt_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PERIOD    = 1000000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              snap_req,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned BPC   = bytes_per_ch(CNT_W);
  localparam int unsigned TMR_W = $clog2(PERIOD);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BI_W  = (BPC > 1) ? $clog2(BPC) : 1;

  if (!params_ok(NUM_CH, CNT_W, PERIOD)) begin : g_bad_params
    $error("perf_event_reporter: illegal NUM_CH/CNT_W/PERIOD combination");
  end

  rpt_state_e       state_q;
  logic [TMR_W-1:0] timer_q;
  logic [7:0]       tx_data_q, seq_q, csum_q, overrun_q;
  logic             tx_valid_q, busy_q;
  logic [CH_W-1:0]  ch_idx_q, nxt_ch_c;
  logic [BI_W-1:0]  byte_idx_q, nxt_byte_c;
  logic [7:0]       nxt_data_c, first_data_c;
  logic             expire_c, trigger_c, snap_c, hs_c, last_byte_c, last_ch_c;
  logic [CNT_W-1:0] shadow [NUM_CH];

  function automatic logic [7:0] pick(input logic [CNT_W-1:0] v, input int unsigned b);
    return 8'(v >> (8 * (BPC - 1 - b)));
  endfunction

  always_comb begin
    expire_c     = en && (timer_q == TMR_W'(PERIOD - 1));
    trigger_c    = expire_c || snap_req;
    snap_c       = trigger_c && (state_q == IDLE);
    hs_c         = tx_valid_q && tx_ready;
    last_byte_c  = (byte_idx_q == BI_W'(BPC - 1));
    last_ch_c    = (ch_idx_q == CH_W'(NUM_CH - 1));
    nxt_byte_c   = last_byte_c ? '0 : byte_idx_q + BI_W'(1);
    nxt_ch_c     = (last_byte_c && !last_ch_c) ? ch_idx_q + CH_W'(1) : ch_idx_q;
    nxt_data_c   = pick(shadow[nxt_ch_c], 32'(nxt_byte_c));
    first_data_c = pick(shadow[0], 32'd0);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_ch_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en),
      .event_i  (event_i[g]),
      .snap_i   (snap_c),
      .shadow_o (shadow[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else if (en) timer_q <= expire_c ? '0 : timer_q + TMR_W'(1);
  end

  // Frame FSM / serializer; tx_data always holds the byte currently offered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      seq_q      <= '0;
      csum_q     <= '0;
      ch_idx_q   <= '0;
      byte_idx_q <= '0;
      overrun_q  <= '0;
    end else begin
      if (trigger_c && (state_q != IDLE) && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
      if (hs_c) csum_q <= csum_q ^ tx_data_q;
      case (state_q)
        IDLE: if (trigger_c) begin
          state_q    <= SYNC;
          tx_valid_q <= 1'b1;
          busy_q     <= 1'b1;
          tx_data_q  <= SYNC_BYTE;
          csum_q     <= '0;
        end
        SYNC: if (hs_c) begin
          state_q   <= SEQ;
          tx_data_q <= seq_q;
        end
        SEQ: if (hs_c) begin
          state_q    <= DATA;
          ch_idx_q   <= '0;
          byte_idx_q <= '0;
          tx_data_q  <= first_data_c;
        end
        DATA: if (hs_c) begin
          if (last_byte_c && last_ch_c) begin
            state_q   <= CSUM;
            tx_data_q <= csum_q ^ tx_data_q;
          end else begin
            ch_idx_q   <= nxt_ch_c;
            byte_idx_q <= nxt_byte_c;
            tx_data_q  <= nxt_data_c;
          end
        end
        CSUM: if (hs_c) begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          seq_q      <= seq_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_perf_event_reporter.sv
// Directed bench for perf_event_reporter (2x16-bit main instance, 1x8-bit saturate/wrap pair).
module tb_perf_event_reporter;

  logic       clk = 1'b0;
  logic       rst, en, snap, rdy;
  logic [1:0] ev;
  logic [7:0] txd, ovr;
  logic       txv, bsy;

  logic       en_b, snap_b, rdy_b;
  logic [0:0] ev_b;
  logic [7:0] txd_b, ovr_b, txd_c, ovr_c;
  logic       txv_b, bsy_b, txv_c, bsy_c;

  int ncmp = 0;
  int nbad = 0;

  logic [7:0] cap  [0:1023];
  logic [7:0] capb [0:63];
  logic [7:0] capc [0:63];
  int ncap = 0, ncapb = 0, ncapc = 0;
  int rd, rdb, rdc, nb, t;
  logic       prev_v, prev_r;
  logic [7:0] prev_d;

  always #5 clk = ~clk;

  perf_event_reporter #(.NUM_CH(2), .CNT_W(16), .PERIOD(100), .SYNC_BYTE(8'hA5), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .event_i(ev), .snap_req(snap), .tx_ready(rdy),
    .tx_data(txd), .tx_valid(txv), .busy(bsy), .overrun_cnt(ovr));

  perf_event_reporter #(.NUM_CH(1), .CNT_W(8), .PERIOD(1000), .SYNC_BYTE(8'hA5), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en_b), .event_i(ev_b), .snap_req(snap_b), .tx_ready(rdy_b),
    .tx_data(txd_b), .tx_valid(txv_b), .busy(bsy_b), .overrun_cnt(ovr_b));

  perf_event_reporter #(.NUM_CH(1), .CNT_W(8), .PERIOD(1000), .SYNC_BYTE(8'hA5), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en_b), .event_i(ev_b), .snap_req(snap_b), .tx_ready(rdy_b),
    .tx_data(txd_c), .tx_valid(txv_c), .busy(bsy_c), .overrun_cnt(ovr_c));

  // Record every accepted byte
  always @(negedge clk) begin
    if (!rst && txv && rdy && ncap < 1024) begin cap[ncap] = txd; ncap++; end
    if (!rst && txv_b && rdy_b && ncapb < 64) begin capb[ncapb] = txd_b; ncapb++; end
    if (!rst && txv_c && rdy_b && ncapc < 64) begin capc[ncapc] = txd_c; ncapc++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ev = 2'b00; snap = 1'b0; rdy = 1'b1;
    en_b = 1'b0; ev_b = 1'b0; snap_b = 1'b0; rdy_b = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    rd = ncap; rdb = ncapb; rdc = ncapc;
  endtask

  task automatic snap_pulse();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [55:0] exp);
    int tw = 0;
    while (ncap < rd + 7 && tw < 3000) begin step(); tw++; end
    chk({tag, "_len"}, 32'(ncap >= rd + 7), 32'd1);
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(cap[rd + i]), 32'(exp[55 - 8*i -: 8]));
    rd += 7;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(txv), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_data", 32'(txd), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    step();

    // Basic frame: ch0 = 10, ch1 = 3
    en = 1'b1; ev = 2'b11;
    repeat (3) step();
    ev = 2'b01;
    repeat (7) step();
    ev = 2'b00;
    snap_pulse();
    @(negedge clk);
    chk("t1_valid", 32'(txv), 32'd1);
    nb = 0;
    for (int i = 0; i < 50; i++) begin
      if (!bsy) break;
      nb++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(nb), 32'd7);
    expect_frame("t1", 56'hA5_00_00_0A_00_03_AC);
    step();
    en = 1'b0;
    snap_pulse();
    expect_frame("t1_seq", 56'hA5_01_00_00_00_00_A4);

    // Saturating vs wrapping 8-bit counters after 300 events
    do_reset();
    en_b = 1'b1; ev_b = 1'b1;
    repeat (300) step();
    ev_b = 1'b0; snap_b = 1'b1;
    step();
    snap_b = 1'b0;
    t = 0;
    while ((ncapb < rdb + 4 || ncapc < rdc + 4) && t < 100) begin step(); t++; end
    chk("t5_sat_cnt", 32'(capb[rdb + 2]), 32'h0000_00FF);
    chk("t5_sat_csum", 32'(capb[rdb + 3]), 32'h0000_005A);
    chk("t5_wrap_cnt", 32'(capc[rdc + 2]), 32'h0000_002C);
    chk("t5_wrap_csum", 32'(capc[rdc + 3]), 32'h0000_0089);

    // Periodic windows with constant ch0 activity
    do_reset();
    en = 1'b1; ev = 2'b01;
    expect_frame("t2_f0", 56'hA5_00_00_64_00_00_C1);
    expect_frame("t2_f1", 56'hA5_01_00_64_00_00_C0);
    expect_frame("t2_f2", 56'hA5_02_00_64_00_00_C3);
    chk("t2_ovr", 32'(ovr), 32'd0);

    // Back-pressure: tx_ready toggling, outputs must hold while stalled
    do_reset();
    en = 1'b1; ev = 2'b11;
    repeat (2) step();
    ev = 2'b01;
    repeat (3) step();
    en = 1'b0; ev = 2'b00;
    snap_pulse();
    prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'h00;
    for (int i = 0; i < 40; i++) begin
      rdy = (i % 2 == 0);
      @(negedge clk);
      if (prev_v && !prev_r) begin
        chk($sformatf("t3_hold_v%0d", i), 32'(txv), 32'd1);
        chk($sformatf("t3_hold_d%0d", i), 32'(txd), 32'(prev_d));
      end
      prev_v = txv; prev_r = rdy; prev_d = txd;
      step();
      if (!bsy) break;
    end
    rdy = 1'b1;
    expect_frame("t3", 56'hA5_00_00_05_00_02_A2);

    // Long stall: two dropped triggers, dropped windows keep accumulating
    do_reset();
    en = 1'b1; ev = 2'b01; rdy = 1'b0;
    repeat (320) step();
    chk("t4_ovr", 32'(ovr), 32'd2);
    chk("t4_busy", 32'(bsy), 32'd1);
    chk("t4_hold_data", 32'(txd), 32'h0000_00A5);
    rdy = 1'b1;
    expect_frame("t4_f0", 56'hA5_00_00_64_00_00_C1);
    expect_frame("t4_f1", 56'hA5_01_01_2C_00_00_89);
    chk("t4_ovr_after", 32'(ovr), 32'd2);

    // Reset in the middle of a frame
    do_reset();
    snap_pulse();
    snap_pulse();
    expect_frame("t6_f0", 56'hA5_00_00_00_00_00_A5);
    chk("t6_ovr_pre", 32'(ovr), 32'd1);
    snap_pulse();
    t = 0;
    while (ncap < rd + 3 && t < 100) begin step(); t++; end
    chk("t6_partial_b0", 32'(cap[rd]), 32'h0000_00A5);
    chk("t6_partial_b1", 32'(cap[rd + 1]), 32'h0000_0001);
    chk("t6_partial_b2", 32'(cap[rd + 2]), 32'h0000_0000);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_valid", 32'(txv), 32'd0);
    chk("t6_busy", 32'(bsy), 32'd0);
    chk("t6_ovr", 32'(ovr), 32'd0);
    step();
    rst = 1'b0;
    rd = ncap;
    step();
    snap_pulse();
    expect_frame("t6_fresh", 56'hA5_00_00_00_00_00_A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
